// File: rtl/fetch_sequencer.sv
// Fetch-stage PC sequencer: owns the program counter, handles branch redirects
// with flush bubbles, stall holds and halt/resume, and flags IF/ID validity.
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_IDLE  | out of reset; one dead cycle for the first imem read
// S_RUN   | normal fetch: increment, stall hold, redirect or halt
// S_FLUSH | bubbles after a taken redirect; PC streams from the target
// S_HALT  | halted, PC held until resume_i

module fetch_sequencer #(
   parameter int PC_W             = 24,
   parameter int REDIRECT_BUBBLES = 2,
   parameter int CNT_W            = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             stall_i,
   input  logic             branch_taken_i,
   input  logic [PC_W-1:0]  branch_target_i,
   input  logic             halt_i,
   input  logic             resume_i,
   output logic [PC_W-1:0]  pc_o,
   output logic             valid_o,
   output logic             flush_o,
   output logic             halted_o,
   output logic [CNT_W-1:0] redirect_cnt_o
);

   localparam int BUB_W = 4;
   localparam logic [BUB_W-1:0] BUB_LOAD = BUB_W'(REDIRECT_BUBBLES);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_FLUSH = 2'd2,
      S_HALT  = 2'd3
   } state_t;

   state_t           state;
   logic [BUB_W-1:0] bub_cnt;

   // Flag outputs are loaded together with the state so they always match it.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state          <= S_IDLE;
         pc_o           <= '0;
         bub_cnt        <= '0;
         redirect_cnt_o <= '0;
         valid_o        <= 1'b0;
         flush_o        <= 1'b0;
         halted_o       <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               state   <= S_RUN;
               valid_o <= 1'b1;
            end

            S_RUN: begin
               if (halt_i) begin
                  state    <= S_HALT;
                  valid_o  <= 1'b0;
                  halted_o <= 1'b1;
               end else if (branch_taken_i) begin
                  state   <= S_FLUSH;
                  pc_o    <= branch_target_i;
                  bub_cnt <= BUB_LOAD;
                  valid_o <= 1'b0;
                  flush_o <= 1'b1;
                  if (redirect_cnt_o != {CNT_W{1'b1}})
                     redirect_cnt_o <= redirect_cnt_o + CNT_W'(1);
               end else if (!stall_i) begin
                  pc_o <= pc_o + PC_W'(1);
               end
            end

            S_FLUSH: begin
               // Requests arriving here belong to squashed instructions.
               pc_o    <= pc_o + PC_W'(1);
               bub_cnt <= bub_cnt - BUB_W'(1);
               if (bub_cnt == BUB_W'(1)) begin
                  state   <= S_RUN;
                  flush_o <= 1'b0;
                  valid_o <= 1'b1;
               end
            end

            S_HALT: begin
               if (resume_i) begin
                  state    <= S_RUN;
                  halted_o <= 1'b0;
                  valid_o  <= 1'b1;
               end
            end

            default: begin
               state    <= S_IDLE;
               valid_o  <= 1'b0;
               flush_o  <= 1'b0;
               halted_o <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: directed scenarios against hand-derived values,
// then randomized traffic against a behavioural model.

module tb_fetch_sequencer;

   localparam int PC_W = 8;
   localparam int RB   = 2;
   localparam int CW   = 2;

   logic            clk = 1'b0;
   logic            reset;
   logic            stall_i, branch_taken_i, halt_i, resume_i;
   logic [PC_W-1:0] branch_target_i;
   logic [PC_W-1:0] pc_o;
   logic            valid_o, flush_o, halted_o;
   logic [CW-1:0]   redirect_cnt_o;

   int n_vec = 0;
   int n_err = 0;

   // behavioural model state
   logic [PC_W-1:0] m_pc;
   logic [CW-1:0]   m_cnt;
   int              m_bub;
   bit              m_started, m_halted;

   logic [PC_W+4+CW-1:0] obs;
   assign obs = {pc_o, valid_o, flush_o, halted_o, redirect_cnt_o};

   fetch_sequencer #(.PC_W(PC_W), .REDIRECT_BUBBLES(RB), .CNT_W(CW)) dut (
      .clk(clk), .reset(reset), .stall_i(stall_i),
      .branch_taken_i(branch_taken_i), .branch_target_i(branch_target_i),
      .halt_i(halt_i), .resume_i(resume_i), .pc_o(pc_o), .valid_o(valid_o),
      .flush_o(flush_o), .halted_o(halted_o), .redirect_cnt_o(redirect_cnt_o)
   );

   always #5 clk = ~clk;

   task automatic model_step();
      if (!reset) begin
         m_pc = '0; m_cnt = '0; m_bub = 0; m_started = 0; m_halted = 0;
      end else if (!m_started) begin
         m_started = 1;
      end else if (m_halted) begin
         if (resume_i) m_halted = 0;
      end else if (m_bub > 0) begin
         m_pc  = m_pc + 1'b1;
         m_bub = m_bub - 1;
      end else if (halt_i) begin
         m_halted = 1;
      end else if (branch_taken_i) begin
         m_pc  = branch_target_i;
         m_bub = RB;
         if (int'(m_cnt) < (1 << CW) - 1) m_cnt = m_cnt + 1'b1;
      end else if (!stall_i) begin
         m_pc = m_pc + 1'b1;
      end
   endtask

   // Inputs are stable across the edge; outputs are sampled 1 time unit later.
   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic idle_inputs();
      stall_i = 0; branch_taken_i = 0; halt_i = 0; resume_i = 0;
      branch_target_i = '0;
   endtask

   task automatic do_reset_and_start(input int run_edges);
      idle_inputs();
      reset = 0; tick(); tick();
      reset = 1; tick();
      repeat (run_edges) tick();
   endtask

   task automatic test_reset();
      idle_inputs();
      reset = 0; tick(); tick();
      n_vec++;
      if (obs !== {8'h00, 1'b0, 1'b0, 1'b0, 2'd0}) begin
         n_err++; $display("FAIL reset_state: got %h want %h", obs, {8'h00, 4'b0000});
      end
      reset = 1; tick();
      n_vec++;
      if (obs !== {8'h00, 1'b1, 1'b0, 1'b0, 2'd0}) begin
         n_err++; $display("FAIL idle_to_run: got %h want %h", obs, {8'h00, 4'b1000});
      end
      for (int i = 1; i <= 3; i++) begin
         tick();
         n_vec++;
         if (obs !== {8'(i), 1'b1, 1'b0, 1'b0, 2'd0}) begin
            n_err++; $display("FAIL seq_pc%0d: got %h want %h", i, obs, {8'(i), 4'b1000});
         end
      end
   endtask

   task automatic test_stall();
      do_reset_and_start(5);
      stall_i = 1;
      for (int i = 0; i < 3; i++) begin
         tick();
         n_vec++;
         if (obs !== {8'h05, 1'b1, 1'b0, 1'b0, 2'd0}) begin
            n_err++; $display("FAIL stall_hold%0d: got %h want %h", i, obs, {8'h05, 4'b1000});
         end
      end
      stall_i = 0; tick();
      n_vec++;
      if (pc_o !== 8'h06) begin
         n_err++; $display("FAIL stall_release: got %h want 06", pc_o);
      end
   endtask

   task automatic test_redirect();
      do_reset_and_start(4);
      branch_taken_i = 1; branch_target_i = 8'h20; tick();
      n_vec++;
      if (obs !== {8'h20, 1'b0, 1'b1, 1'b0, 2'd1}) begin
         n_err++; $display("FAIL redir_edge1: got %h want %h", obs, {8'h20, 4'b0101});
      end
      branch_target_i = 8'h80; tick();   // ignored: arrives during FLUSH
      branch_taken_i = 0;
      n_vec++;
      if (obs !== {8'h21, 1'b0, 1'b1, 1'b0, 2'd1}) begin
         n_err++; $display("FAIL redir_edge2: got %h want %h", obs, {8'h21, 4'b0101});
      end
      tick();
      n_vec++;
      if (obs !== {8'h22, 1'b1, 1'b0, 1'b0, 2'd1}) begin
         n_err++; $display("FAIL redir_edge3: got %h want %h", obs, {8'h22, 4'b1001});
      end
      tick();
      n_vec++;
      if (obs !== {8'h23, 1'b1, 1'b0, 1'b0, 2'd1}) begin
         n_err++; $display("FAIL redir_after: got %h want %h", obs, {8'h23, 4'b1001});
      end
   endtask

   task automatic test_priority_halt();
      do_reset_and_start(9);
      halt_i = 1; branch_taken_i = 1; branch_target_i = 8'h40; tick();
      n_vec++;
      if (obs !== {8'h09, 1'b0, 1'b0, 1'b1, 2'd0}) begin
         n_err++; $display("FAIL halt_enter: got %h want %h", obs, {8'h09, 4'b0010});
      end
      for (int i = 0; i < 3; i++) begin
         tick();
         n_vec++;
         if (obs !== {8'h09, 1'b0, 1'b0, 1'b1, 2'd0}) begin
            n_err++; $display("FAIL halt_hold%0d: got %h want %h", i, obs, {8'h09, 4'b0010});
         end
      end
      halt_i = 0; branch_taken_i = 0; resume_i = 1; tick();
      resume_i = 0;
      n_vec++;
      if (obs !== {8'h09, 1'b1, 1'b0, 1'b0, 2'd0}) begin
         n_err++; $display("FAIL resume: got %h want %h", obs, {8'h09, 4'b1000});
      end
      tick();
      n_vec++;
      if (pc_o !== 8'h0A) begin
         n_err++; $display("FAIL resume_inc: got %h want 0a", pc_o);
      end
   endtask

   task automatic test_wrap_saturation();
      logic [PC_W-1:0] exp_pc [4];
      logic            exp_run [4];
      exp_pc  = '{8'hFD, 8'hFE, 8'hFF, 8'h00};
      exp_run = '{1'b0, 1'b0, 1'b1, 1'b1};
      do_reset_and_start(0);
      branch_taken_i = 1; branch_target_i = 8'hFD;
      for (int i = 0; i < 4; i++) begin
         tick();
         branch_taken_i = 0;
         n_vec++;
         if (pc_o !== exp_pc[i] || valid_o !== exp_run[i] || flush_o !== !exp_run[i]) begin
            n_err++;
            $display("FAIL wrap%0d: got pc=%h v=%b f=%b want pc=%h v=%b f=%b",
                     i, pc_o, valid_o, flush_o, exp_pc[i], exp_run[i], !exp_run[i]);
         end
      end
      for (int k = 2; k <= 5; k++) begin
         branch_taken_i = 1; branch_target_i = 8'(k * 16); tick();
         branch_taken_i = 0; tick(); tick();
         n_vec++;
         if (redirect_cnt_o !== CW'((k > 3) ? 3 : k)) begin
            n_err++; $display("FAIL sat_cnt%0d: got %0d want %0d", k, redirect_cnt_o, (k > 3) ? 3 : k);
         end
      end
   endtask

   task automatic test_reset_mid();
      do_reset_and_start(4);
      branch_taken_i = 1; branch_target_i = 8'h20; tick();
      branch_taken_i = 0; tick();
      reset = 0; tick();
      n_vec++;
      if (obs !== {8'h00, 1'b0, 1'b0, 1'b0, 2'd0}) begin
         n_err++; $display("FAIL rst_flush: got %h want %h", obs, {8'h00, 4'b0000});
      end
      reset = 1; tick();
      n_vec++;
      if (obs !== {8'h00, 1'b1, 1'b0, 1'b0, 2'd0}) begin
         n_err++; $display("FAIL rst_flush_run: got %h want %h", obs, {8'h00, 4'b1000});
      end
      tick();
      branch_taken_i = 1; branch_target_i = 8'h10; tick();
      branch_taken_i = 0; tick(); tick();
      halt_i = 1; tick();
      halt_i = 0;
      n_vec++;
      if (obs !== {8'h12, 1'b0, 1'b0, 1'b1, 2'd1}) begin
         n_err++; $display("FAIL pre_rst_halt: got %h want %h", obs, {8'h12, 4'b0011});
      end
      reset = 0; tick();
      n_vec++;
      if (obs !== {8'h00, 1'b0, 1'b0, 1'b0, 2'd0}) begin
         n_err++; $display("FAIL rst_halt: got %h want %h", obs, {8'h00, 4'b0000});
      end
      reset = 1; tick(); tick();
      n_vec++;
      if (obs !== {8'h01, 1'b1, 1'b0, 1'b0, 2'd0}) begin
         n_err++; $display("FAIL rst_halt_seq: got %h want %h", obs, {8'h01, 4'b1000});
      end
   endtask

   task automatic test_random();
      do_reset_and_start(0);
      for (int i = 0; i < 3000; i++) begin
         reset           = ($urandom_range(0, 99) != 0);
         stall_i         = ($urandom_range(0, 3) == 0);
         branch_taken_i  = ($urandom_range(0, 5) == 0);
         halt_i          = ($urandom_range(0, 15) == 0);
         resume_i        = ($urandom_range(0, 3) == 0);
         branch_target_i = PC_W'($urandom);
         tick();
         n_vec++;
         if (pc_o !== m_pc || redirect_cnt_o !== m_cnt ||
             valid_o !== (m_started && !m_halted && m_bub == 0) ||
             flush_o !== (m_bub > 0) || halted_o !== m_halted) begin
            n_err++;
            $display("FAIL random%0d: got pc=%h v=%b f=%b h=%b c=%0d want pc=%h v=%b f=%b h=%b c=%0d",
                     i, pc_o, valid_o, flush_o, halted_o, redirect_cnt_o, m_pc,
                     m_started && !m_halted && m_bub == 0, m_bub > 0, m_halted, m_cnt);
         end
      end
      idle_inputs();
      reset = 1;
   endtask

   initial begin
      idle_inputs();
      reset = 0;
      test_reset();
      test_stall();
      test_redirect();
      test_priority_halt();
      test_wrap_saturation();
      test_reset_mid();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
PC sequencing controller for the 24-bit fetch stage. It owns the program counter and drives the fetch address (newPc). Each cycle it picks the next PC: sequential increment, branch redirect, stall hold or halt. After a redirect it inserts flush bubbles to cover the fetch-path PC register latency, and tells the IF/ID register whether the fetched instruction is valid.

Parameters:
PC_W, 24, width of PC / fetch address; PC arithmetic is modulo 2^PC_W
REDIRECT_BUBBLES, 2, flush cycles after a taken branch; legal range 1..15
CNT_W, 16, width of the taken-redirect performance counter

Ports:
clk  in  1  single system clock, rising edge
reset  in  1  synchronous, active-low reset (0 = reset asserted)
stall_i  in  1  hazard-unit stall request; hold PC
branch_taken_i  in  1  execute resolved a taken branch/jump this cycle
branch_target_i  in  PC_W  redirect target, sampled when branch_taken_i is accepted
halt_i  in  1  decode found a halt opcode
resume_i  in  1  leave HALT
pc_o  out  PC_W  fetch address (newPc to fetch stage), registered
valid_o  out  1  instruction entering IF/ID is valid, registered
flush_o  out  1  kill IF/ID contents, registered
halted_o  out  1  sequencer in HALT, registered
redirect_cnt_o  out  CNT_W  accepted redirects, saturating, registered

Behaviour:
- All state changes occur on the rising clk edge. reset=0 at an edge puts the block in IDLE from any state, including mid-FLUSH and HALT, with pc_o=0, redirect_cnt_o=0 and the bubble counter at 0.
- Outputs are Moore, decoded from the registered state: valid_o=(RUN), flush_o=(FLUSH), halted_o=(HALT). In IDLE all three are 0.
- IDLE: the next edge with reset=1 moves to RUN and holds pc_o. This gives one dead cycle for the first instruction-memory read.
- RUN: per-edge priority is halt_i > branch_taken_i > stall_i > increment.
  - halt_i: go to HALT, hold pc_o. A branch in the same cycle is dropped and not counted.
  - branch_taken_i: pc_o<=branch_target_i, go to FLUSH, bubble counter<=REDIRECT_BUBBLES, redirect_cnt_o increments (saturates at all-ones).
  - stall_i: hold pc_o, stay in RUN; valid_o stays 1 so IF/ID holds its contents.
  - otherwise: pc_o<=pc_o+1, wrapping from 2^PC_W-1 to 0.
- FLUSH: pc_o<=pc_o+1 every edge so fetch keeps streaming from the target. The counter decrements each edge; an edge with counter==1 moves to RUN. FLUSH therefore lasts exactly REDIRECT_BUBBLES cycles. stall_i, branch_taken_i and halt_i are ignored, because they come from squashed instructions.
- HALT: pc_o holds. resume_i moves to RUN with pc_o unchanged, so the PC after the halt is refetched. halt_i and branch_taken_i are ignored here.
- Latency: a redirect presented in cycle N gives pc_o=target after edge N. valid_o returns to 1 REDIRECT_BUBBLES cycles later.
- No combinational path from any input to any output.

Test Plan:
1. Reset/sequential (PC_W=8): hold reset=0 for 2 edges -> pc_o=0, valid_o=0; release -> first edge IDLE->RUN with pc_o=0, valid_o=1; next three edges -> pc_o=1,2,3.
2. Stall: RUN with pc_o=5, stall_i=1 for 3 edges -> pc_o stays 5, valid_o=1, flush_o=0; drop stall -> next edge pc_o=6.
3. Redirect (REDIRECT_BUBBLES=2): at pc_o=4 pulse branch_taken_i with target 0x20 -> edge1 pc_o=0x20, flush_o=1, valid_o=0; edge2 pc_o=0x21, flush_o=1; edge3 pc_o=0x22, flush_o=0, valid_o=1; redirect_cnt_o=1. A second branch_taken_i pulsed during edge2 has no effect.
4. Priority/halt: at pc_o=9 assert halt_i and branch_taken_i (target 0x40) together -> HALT, pc_o=9, halted_o=1, redirect_cnt_o unchanged; hold 3 cycles -> pc_o stays 9; pulse resume_i -> RUN with pc_o=9, then next edge pc_o=10.
5. Wrap/saturation (PC_W=8, CNT_W=2): run from pc_o=0xFE -> pc_o=0xFF then 0x00; four accepted redirects -> redirect_cnt_o=3 and stays 3.
6. Reset mid-operation: assert reset=0 during FLUSH (pc_o=0x21) and during HALT -> next edge pc_o=0, all flags 0, redirect_cnt_o=0; release -> IDLE then RUN, same sequence as scenario 1.
